// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 (double-dabble) binary to packed BCD converter.
// One conversion per accepted start; optional leading-zero blanking to 4'hF.
module bin_to_bcd_seq #(
  parameter int IN_W     = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state, state_nx;
  logic [IN_W-1:0] shreg;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   blanked;
  logic [CW-1:0]   cnt;
  logic            acc;
  logic            lead;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-digit add-3 correction, no carry between digits.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Blank zeros from the top until the first nonzero digit; digit 0 always shown.
  always_comb begin
    blanked = scratch;
    lead    = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (BLANK_LZ != 0 && lead && scratch[4*i +: 4] == 4'd0) blanked[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      acc     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd     <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            acc     <= 1'b0;
            cnt     <= CW'(IN_W);
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          acc              <= acc | adj[BW-1];
          cnt              <= cnt - 1'b1;
        end
        FINISH: begin
          bcd  <= blanked;
          ovf  <= acc;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default config plus no-blanking and
// two-digit instances sharing the same start/bin stimulus.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;

  logic        busy, done, ovf;
  logic [11:0] bcd;
  logic        busy_nb, done_nb, ovf_nb;
  logic [11:0] bcd_nb;
  logic        busy_d2, done_d2, ovf_d2;
  logic [7:0]  bcd_d2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(3), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(3), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .ovf(ovf_nb)
  );

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(2), .BLANK_LZ(1)) dut_d2 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_d2), .done(done_d2), .bcd(bcd_d2), .ovf(ovf_d2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start with value v at the current point (1ns after an edge),
  // then waits (bounded) for done. edges counts edges after the accept edge.
  task automatic run(input logic [7:0] v, output int edges,
                     output logic busy_ok, output logic hold_ok);
    logic [11:0] prev;
    prev    = bcd;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    start   = 1'b1;
    bin     = v;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    while (done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (done !== 1'b1) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (bcd !== prev) hold_ok = 1'b0;
      end
    end
  endtask

  task automatic idle_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    int   e;
    int   pulses;
    logic bok, hok;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_bcd", bcd, 12'hFFF);
    chk("reset_bcd_d2", bcd_d2, 8'hFF);
    #10 rst = 1'b0;
    idle_edge();

    // 255: full latency and pulse shape
    run(8'd255, e, bok, hok);
    chk("lat_255", e, 9);
    chk("bcd_255", bcd, 12'h255);
    chk("ovf_255", ovf, 0);
    chk("busy_low_255", busy, 0);
    chk("done_255", done, 1);
    chk("busy_during_255", bok, 1);
    chk("hold_before_255", hok, 1);
    chk("d2_bcd_255", bcd_d2, 8'h55);
    chk("d2_ovf_255", ovf_d2, 1);
    idle_edge();
    chk("done_drop_255", done, 0);
    chk("bcd_hold_255", bcd, 12'h255);

    run(8'd0, e, bok, hok);
    chk("bcd_0", bcd, 12'hFF0);
    chk("nb_bcd_0", bcd_nb, 12'h000);
    chk("d2_bcd_0", bcd_d2, 8'hF0);
    idle_edge();

    run(8'd7, e, bok, hok);
    chk("bcd_7", bcd, 12'hFF7);
    chk("nb_bcd_7", bcd_nb, 12'h007);
    chk("d2_bcd_7", bcd_d2, 8'hF7);
    idle_edge();

    run(8'd42, e, bok, hok);
    chk("bcd_42", bcd, 12'hF42);
    chk("nb_bcd_42", bcd_nb, 12'h042);
    chk("d2_bcd_42", bcd_d2, 8'h42);
    chk("d2_ovf_42", ovf_d2, 0);
    idle_edge();

    run(8'd100, e, bok, hok);
    chk("bcd_100", bcd, 12'h100);
    chk("ovf_100", ovf, 0);
    chk("d2_bcd_100", bcd_d2, 8'hF0);
    chk("d2_ovf_100", ovf_d2, 1);
    idle_edge();

    // Start while busy: second request at edge 4 must be ignored
    start = 1'b1;
    bin   = 8'd13;
    @(posedge clk); #1;
    start = 1'b0;
    e   = 0;
    bok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e++;
      if (busy !== 1'b1) bok = 1'b0;
    end
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk); #1;
    e++;
    start = 1'b0;
    bin   = 8'd77;
    while (done !== 1'b1 && e < 20) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(posedge clk); #1;
      e++;
    end
    chk("lat_busy_ign", e, 9);
    chk("bcd_busy_ign", bcd, 12'hF13);
    chk("busy_held_ign", bok, 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("single_done_ign", pulses, 0);
    chk("idle_after_ign", busy, 0);

    // Back-to-back: second start raised in the done cycle
    run(8'd99, e, bok, hok);
    chk("bcd_99", bcd, 12'hF99);
    chk("d2_bcd_99", bcd_d2, 8'h99);
    chk("d2_ovf_99", ovf_d2, 0);
    run(8'd128, e, bok, hok);
    chk("lat_b2b", e, 9);
    chk("hold_b2b", hok, 1);
    chk("busy_b2b", bok, 1);
    chk("bcd_128", bcd, 12'h128);
    idle_edge();

    // Asynchronous reset mid-conversion
    start = 1'b1;
    bin   = 8'd250;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) idle_edge();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_bcd", bcd, 12'hFFF);
    chk("rst_mid_done", done, 0);
    @(posedge clk);
    #4 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("rst_no_done", pulses, 0);
    chk("rst_bcd_dark", bcd, 12'hFFF);
    run(8'd1, e, bok, hok);
    chk("lat_1", e, 9);
    chk("bcd_1", bcd, 12'hFF1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits.
- Sits directly upstream of the per-digit 7-segment decoders. Each 4-bit digit output drives one decoder's num input.
- Optional leading-zero blanking replaces leading zero digits with 4'hF. Decoders show all segments off for codes 10-15.
- Intended source: the multiplier/calculator result, converted once per start pulse.

Parameters:
- IN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD digits produced. Digit 0 is least significant.
- BLANK_LZ, 1, when 1 the leading zero digits are output as 4'hF. The least significant digit is never blanked.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request, sampled only in IDLE.
- bin  input  IN_W  unsigned value, captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse, high in the cycle bcd/ovf first show a new result.
- bcd  output  4*DIGITS  packed digits; bcd[3:0] is digit 0 (ones).
- ovf  output  1  result did not fit in DIGITS digits; registered with bcd.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, ovf=0, bcd=all digits 4'hF (display dark), internal shift/scratch/counter=0.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On an edge with start=1: capture bin into the shift register, clear the BCD scratch and the overflow accumulator, counter=IN_W, busy<=1, go SHIFT.
  - With start=0: stay in IDLE. bcd and ovf hold.
- SHIFT, one iteration per edge:
  - First, add 3 to every scratch digit whose value is >=5 (4-bit add, no carry between digits).
  - Then shift {scratch, shreg} left by 1.
  - OR the bit leaving the top digit into the overflow accumulator.
  - Decrement the counter. On the edge where the counter goes 1->0, go FINISH.
  - Exactly IN_W SHIFT edges occur.
- FINISH, one edge:
  - Load bcd from the scratch, with leading-zero blanking applied when BLANK_LZ=1.
  - ovf<=accumulator, done<=1, busy<=0, go IDLE.
- done deasserts on the next edge.
- Blanking rule: scan digits from the top. Every digit that is 0 with all higher digits 0 becomes 4'hF. Digit 0 is always shown. Interior zeros are kept.
- Latency: start sampled at edge E0. done=1 and the new bcd are visible after edge E0+IN_W+1 (9 edges for IN_W=8). busy is high from E0 until E0+IN_W+1.
- start while busy=1: ignored, no queueing. bin changes after the capture edge have no effect.
- Back-to-back:
  - start=1 in the cycle done=1 is accepted, since the block is already in IDLE.
  - The next result follows IN_W+1 edges later.
  - The previous bcd holds until then.
- ovf: when set, bcd holds the low DIGITS digits of the true value (modulo 10^DIGITS).
- Reset mid-conversion: the conversion is aborted, the reset values above apply, and no done pulse is produced.

Test Plan:
- IN_W=8, DIGITS=3, BLANK_LZ=1: reset -> busy=0, done=0, ovf=0, bcd=12'hFFF. Pulse start with bin=255 -> done after exactly 9 edges, bcd=12'h255, ovf=0, busy low the same cycle, done high exactly 1 cycle.
- Blanking: bin=0 -> bcd=12'hFF0. bin=7 -> 12'hFF7. bin=42 -> 12'hF42. bin=100 -> 12'h100 (interior zeros kept). With BLANK_LZ=0, bin=7 -> 12'h007.
- Start while busy: start with bin=13, then start with bin=200 at edge 4 -> second request ignored, result 12'hF13, single done pulse, busy stays high throughout.
- Back-to-back: start with bin=99, then start with bin=128 held high during the done cycle -> results 12'hF99 then 12'h128, spaced 9 edges apart. bcd stays 12'hF99 in between.
- Reset mid-operation: assert rst asynchronously (between clock edges) 5 edges after start with bin=250 -> busy=0 and bcd=12'hFFF immediately, no done pulse. After release, a start with bin=1 -> 12'hFF1.
- Overflow, DIGITS=2: bin=100 -> bcd=8'hF0 (the ones digit 0 is never blanked, and the tens digit 0 is a leading zero so it becomes F), ovf=1. bin=99 -> 8'h99, ovf=0.
